// File: rtl/csr_timer_intc.sv
// CSR-mapped countdown timers with prescalers, a 64-bit stable counter with offset,
// and a registered priority encoder that feeds has_int/int_ecode to commit.
module csr_timer_intc #(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_W      = 32,
    parameter int          PRESC_W    = 8,
    parameter int          HWI_NUM    = 8,
    parameter logic [13:0] CSR_BASE   = 14'h040
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               csr_we,
    input  logic [13:0]                        csr_waddr,
    input  logic [31:0]                        csr_wmask,
    input  logic [31:0]                        csr_wdata,
    input  logic [13:0]                        csr_raddr,
    output logic [31:0]                        csr_rdata,
    output logic                               csr_hit,
    input  logic [HWI_NUM-1:0]                 hw_int,
    input  logic [1:0]                         sw_int,
    input  logic                               ie,
    output logic [2+HWI_NUM+NUM_TIMERS-1:0]    int_pending,
    output logic                               has_int,
    output logic [7:0]                         int_ecode,
    output logic [63:0]                        counter,
    output logic [63:0]                        counter_out
);
    localparam int          P         = 2 + HWI_NUM + NUM_TIMERS;
    localparam int          WIN       = 4 * NUM_TIMERS + 4;
    localparam logic [13:0] CNTC_ADDR = CSR_BASE + 14'(4 * NUM_TIMERS);
    localparam logic [13:0] LIE_ADDR  = CNTC_ADDR + 14'd1;

    logic [CNT_W-1:0]   tcfg_q      [NUM_TIMERS];
    logic [CNT_W-1:0]   tcfg_d      [NUM_TIMERS];
    logic [CNT_W-1:0]   tval_q      [NUM_TIMERS];
    logic [CNT_W-1:0]   tval_d      [NUM_TIMERS];
    logic [PRESC_W-1:0] tpresc_q    [NUM_TIMERS];
    logic [PRESC_W-1:0] tpresc_d    [NUM_TIMERS];
    logic [PRESC_W-1:0] presc_cnt_q [NUM_TIMERS];
    logic [PRESC_W-1:0] presc_cnt_d [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] running_q, running_d;
    logic [NUM_TIMERS-1:0] ti_q, ti_d;
    logic [NUM_TIMERS-1:0] tick;
    logic [31:0]        cntc_q, cntc_d;
    logic [P-1:0]       lie_q, lie_d;
    logic [HWI_NUM-1:0] hw_meta_q, hw_sync_q;
    logic               has_int_q, has_int_d;
    logic [7:0]         int_ecode_q, int_ecode_d;
    logic [63:0]        counter_q;
    logic [P-1:0]       masked;
    logic [13:0]        roff;

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_tick
        assign tick[gi] = (presc_cnt_q[gi] == tpresc_q[gi]);
    end

    assign int_pending = {ti_q, hw_sync_q, sw_int};
    assign masked      = int_pending & lie_q;

    always_comb begin
        logic [CNT_W-1:0] tcfg_m;
        logic             expire;
        tcfg_d      = tcfg_q;
        tval_d      = tval_q;
        tpresc_d    = tpresc_q;
        presc_cnt_d = presc_cnt_q;
        running_d   = running_q;
        ti_d        = ti_q;
        cntc_d      = cntc_q;
        lie_d       = lie_q;
        tcfg_m      = '0;
        expire      = 1'b0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            expire         = 1'b0;
            presc_cnt_d[i] = tick[i] ? '0 : presc_cnt_q[i] + 1'b1;
            if (running_q[i] && tick[i]) begin
                if (tval_q[i] != '0) begin
                    tval_d[i] = tval_q[i] - 1'b1;
                end else begin
                    expire = 1'b1;
                    if (tcfg_q[i][1]) begin
                        tval_d[i] = {tcfg_q[i][CNT_W-1:2], 2'b00};
                    end else begin
                        tval_d[i]    = '1;
                        running_d[i] = 1'b0;
                    end
                end
            end
            tcfg_m = (tcfg_q[i] & ~csr_wmask[CNT_W-1:0]) | (csr_wdata[CNT_W-1:0] & csr_wmask[CNT_W-1:0]);
            // A config write restarts the timer and swallows any expiry in the same cycle.
            if (csr_we && csr_waddr == CSR_BASE + 14'(4 * i)) begin
                tcfg_d[i]      = tcfg_m;
                tval_d[i]      = {tcfg_m[CNT_W-1:2], 2'b00};
                presc_cnt_d[i] = '0;
                running_d[i]   = tcfg_m[0];
                expire         = 1'b0;
            end
            if (csr_we && csr_waddr == CSR_BASE + 14'(4 * i + 3)) begin
                tpresc_d[i] = (tpresc_q[i] & ~csr_wmask[PRESC_W-1:0]) | (csr_wdata[PRESC_W-1:0] & csr_wmask[PRESC_W-1:0]);
            end
            if (csr_we && csr_waddr == CSR_BASE + 14'(4 * i + 2) && csr_wdata[0] && csr_wmask[0]) begin
                ti_d[i] = 1'b0;
            end
            if (expire) begin
                ti_d[i] = 1'b1;
            end
        end
        if (csr_we && csr_waddr == CNTC_ADDR) begin
            cntc_d = (cntc_q & ~csr_wmask) | (csr_wdata & csr_wmask);
        end
        if (csr_we && csr_waddr == LIE_ADDR) begin
            lie_d = (lie_q & ~csr_wmask[P-1:0]) | (csr_wdata[P-1:0] & csr_wmask[P-1:0]);
        end
    end

    always_comb begin
        has_int_d   = ie & (|masked);
        int_ecode_d = 8'd0;
        for (int k = 0; k < P; k++) begin
            if (masked[k]) begin
                int_ecode_d = 8'(64 + k);
            end
        end
    end

    assign roff    = csr_raddr - CSR_BASE;
    assign csr_hit = (roff < 14'(WIN));

    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (csr_raddr == CSR_BASE + 14'(4 * i)) begin
                csr_rdata[CNT_W-1:0] = tcfg_q[i];
            end
            if (csr_raddr == CSR_BASE + 14'(4 * i + 1)) begin
                csr_rdata[CNT_W-1:0] = tval_q[i];
            end
            if (csr_raddr == CSR_BASE + 14'(4 * i + 3)) begin
                csr_rdata[PRESC_W-1:0] = tpresc_q[i];
            end
        end
        if (csr_raddr == CNTC_ADDR) begin
            csr_rdata = cntc_q;
        end
        if (csr_raddr == LIE_ADDR) begin
            csr_rdata[P-1:0] = lie_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                tcfg_q[i]      <= '0;
                tval_q[i]      <= '1;
                tpresc_q[i]    <= '0;
                presc_cnt_q[i] <= '0;
            end
            running_q   <= '0;
            ti_q        <= '0;
            cntc_q      <= '0;
            lie_q       <= '0;
            hw_meta_q   <= '0;
            hw_sync_q   <= '0;
            has_int_q   <= 1'b0;
            int_ecode_q <= 8'd0;
            counter_q   <= '0;
        end else begin
            tcfg_q      <= tcfg_d;
            tval_q      <= tval_d;
            tpresc_q    <= tpresc_d;
            presc_cnt_q <= presc_cnt_d;
            running_q   <= running_d;
            ti_q        <= ti_d;
            cntc_q      <= cntc_d;
            lie_q       <= lie_d;
            hw_meta_q   <= hw_int;
            hw_sync_q   <= hw_meta_q;
            has_int_q   <= has_int_d;
            int_ecode_q <= int_ecode_d;
            counter_q   <= counter_q + 64'd1;
        end
    end

    assign has_int     = has_int_q;
    assign int_ecode   = int_ecode_q;
    assign counter     = counter_q;
    assign counter_out = counter_q + {{32{cntc_q[31]}}, cntc_q};
endmodule

// File: tb/tb_csr_timer_intc.sv
// Directed bench for csr_timer_intc: timers, prescaler, W1C clear, encoder priority,
// reset abort and the offset counter, with hand-computed expectations.
module tb_csr_timer_intc;
    logic        clk;
    logic        rstn;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [7:0]  hw_int;
    logic [1:0]  sw_int;
    logic        ie;
    logic [11:0] int_pending;
    logic        has_int;
    logic [7:0]  int_ecode;
    logic [63:0] counter;
    logic [63:0] counter_out;

    int n_cmp = 0;
    int n_err = 0;

    csr_timer_intc dut (
        .clk         (clk),
        .rstn        (rstn),
        .csr_we      (csr_we),
        .csr_waddr   (csr_waddr),
        .csr_wmask   (csr_wmask),
        .csr_wdata   (csr_wdata),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .hw_int      (hw_int),
        .sw_int      (sw_int),
        .ie          (ie),
        .int_pending (int_pending),
        .has_int     (has_int),
        .int_ecode   (int_ecode),
        .counter     (counter),
        .counter_out (counter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_we    = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
        csr_wmask = m;
        @(negedge clk);
        csr_we    = 1'b0;
        csr_wmask = '0;
        $display("write addr=%0h data=%0h mask=%0h", a, d, m);
    endtask

    initial begin
        rstn = 1'b0; csr_we = 1'b0; csr_waddr = '0; csr_wmask = '0; csr_wdata = '0;
        csr_raddr = '0; hw_int = '0; sw_int = '0; ie = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state and window decode
        rd("rst_tval0", 14'h041, 32'hFFFF_FFFF);
        chk("rst_pending", int_pending, 0);
        chk("rst_has_int", has_int, 0);
        chk("rst_ecode", int_ecode, 0);
        chk("rst_counter", counter, 0);
        rd("rst_lie", 14'h049, 0);
        chk("hit_base", csr_hit, 1);
        csr_raddr = 14'h03F; #1; chk("hit_below", csr_hit, 0);
        rd("rd_below", 14'h03F, 0);
        csr_raddr = 14'h04B; #1; chk("hit_hole", csr_hit, 1);
        rd("rd_hole", 14'h04B, 0);
        csr_raddr = 14'h04C; #1; chk("hit_above", csr_hit, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("cnt_first", counter, 1);

        // T1 one-shot
        ie = 1'b1;
        wr(14'h049, 32'hFFF, 32'hFFFF_FFFF);
        wr(14'h040, 32'h11, 32'hFFFF_FFFF);
        rd("t1_tval_load", 14'h041, 32'h10);
        rd("t1_tcfg", 14'h040, 32'h11);
        repeat (16) @(negedge clk);
        rd("t1_tval_zero", 14'h041, 0);
        chk("t1_ti_early", int_pending[10], 0);
        @(negedge clk);
        chk("t1_ti_set", int_pending[10], 1);
        chk("t1_hasint_lat", has_int, 0);
        rd("t1_tval_ones", 14'h041, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t1_has_int", has_int, 1);
        chk("t1_ecode", int_ecode, 74);
        wr(14'h042, 32'h1, 32'hFFFF_FFFF);
        chk("t1_ticlr", int_pending[10], 0);
        rd("t1_ticlr_rd", 14'h042, 0);
        wr(14'h041, 32'h5, 32'hFFFF_FFFF);
        repeat (20) @(negedge clk);
        chk("t1_no_reset", int_pending[10], 0);
        rd("t1_tval_ro", 14'h041, 32'hFFFF_FFFF);
        chk("t1_has_int_0", has_int, 0);

        // T2 periodic, W1C clear and set-wins overlap
        wr(14'h040, 32'h0B, 32'hFFFF_FFFF);
        repeat (8) @(negedge clk);
        chk("t2_ti_early", int_pending[10], 0);
        rd("t2_tval_zero", 14'h041, 0);
        @(negedge clk);
        chk("t2_ti_9", int_pending[10], 1);
        rd("t2_reload", 14'h041, 32'h8);
        wr(14'h042, 32'h1, 32'h1);
        chk("t2_clear", int_pending[10], 0);
        repeat (7) @(negedge clk);
        chk("t2_before_exp", int_pending[10], 0);
        wr(14'h042, 32'h1, 32'hFFFF_FFFF);
        chk("t2_set_wins", int_pending[10], 1);
        wr(14'h040, 32'h0, 32'hFFFF_FFFF);
        wr(14'h042, 32'h1, 32'hFFFF_FFFF);
        chk("t2_stopped", int_pending[10], 0);

        // T3 prescaler
        wr(14'h047, 32'h3, 32'hFFFF_FFFF);
        wr(14'h044, 32'h05, 32'hFFFF_FFFF);
        rd("t3_presc_rd", 14'h047, 32'h3);
        rd("t3_tval_load", 14'h045, 32'h4);
        repeat (3) @(negedge clk);
        rd("t3_tval_hold", 14'h045, 32'h4);
        @(negedge clk);
        rd("t3_tval_step", 14'h045, 32'h3);
        repeat (15) @(negedge clk);
        rd("t3_tval_zero", 14'h045, 0);
        chk("t3_ti_early", int_pending[11], 0);
        @(negedge clk);
        chk("t3_ti_20", int_pending[11], 1);

        // T4 priority encoder
        hw_int = 8'h08;
        @(negedge clk);
        chk("t4_sync1", int_pending[5], 0);
        @(negedge clk);
        chk("t4_sync2", int_pending[5], 1);
        @(negedge clk);
        chk("t4_ecode75", int_ecode, 75);
        wr(14'h049, 32'h0, 32'h800);
        chk("t4_ecode_lat", int_ecode, 75);
        rd("t4_lie_rd", 14'h049, 32'h7FF);
        @(negedge clk);
        chk("t4_ecode69", int_ecode, 69);
        ie = 1'b0;
        @(negedge clk);
        chk("t4_ie_off", has_int, 0);
        sw_int = 2'b01; #1;
        chk("t4_sw_int", int_pending[1:0], 2'b01);
        sw_int = 2'b00;
        hw_int = 8'h00;
        ie = 1'b1;
        @(negedge clk);
        wr(14'h044, 32'h0, 32'hFFFF_FFFF);
        wr(14'h046, 32'h1, 32'hFFFF_FFFF);
        chk("t4_ti1_clr", int_pending[11], 0);

        // T5 masked write and config/expiry overlap
        wr(14'h040, 32'h0A, 32'hFFFF_FFFF);
        wr(14'h040, 32'hFFFF_FFF1, 32'h1);
        rd("t5_tcfg_mask", 14'h040, 32'h0B);
        rd("t5_tval_keep", 14'h041, 32'h8);
        repeat (8) @(negedge clk);
        rd("t5_tval_zero", 14'h041, 0);
        wr(14'h040, 32'h13, 32'hFFFF_FFFF);
        chk("t5_no_ti", int_pending[10], 0);
        rd("t5_reload", 14'h041, 32'h10);
        @(negedge clk);
        rd("t5_counting", 14'h041, 32'hF);
        wr(14'h040, 32'h0, 32'hFFFF_FFFF);

        // T6 reset mid-count and counter offset
        wr(14'h044, 32'h21, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        rd("t6_midcount", 14'h045, 32'h1E);
        hw_int = 8'h01;
        repeat (3) @(negedge clk);
        chk("t6_hw_pend", int_pending[2], 1);
        chk("t6_has_int", has_int, 1);
        chk("t6_ecode66", int_ecode, 66);
        rstn = 1'b0;
        hw_int = 8'h00;
        @(negedge clk);
        rd("t6_rst_tval", 14'h045, 32'hFFFF_FFFF);
        rd("t6_rst_presc", 14'h047, 0);
        chk("t6_rst_pend", int_pending, 0);
        chk("t6_rst_hasint", has_int, 0);
        chk("t6_rst_ecode", int_ecode, 0);
        chk("t6_rst_cnt", counter, 0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        rd("t6_aborted", 14'h045, 32'hFFFF_FFFF);
        chk("t6_cnt10", counter, 10);
        wr(14'h048, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t6_cnt11", counter, 11);
        chk("t6_cntout_neg", counter_out, 10);
        wr(14'h048, 32'h10, 32'hFFFF_FFFF);
        chk("t6_cntout_pos", counter_out, 64'h1C);
        rd("t6_cntc_rd", 14'h048, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
